// File: rtl/hex_scan_display_pkg.sv
// Shared constants for the hex scan display: segment bit order, active-low
// hex glyphs (0-F with lowercase b and d) and the blank pattern.
package hex_scan_display_pkg;

    localparam int SEG_WIDTH = 7;

    typedef logic [SEG_WIDTH-1:0] seg_t;

    // Bit position of each segment on the seg_n bus.
    typedef enum int unsigned {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit0 = a ... bit6 = g.
    localparam seg_t GLYPH_0 = 7'h40;
    localparam seg_t GLYPH_1 = 7'h79;
    localparam seg_t GLYPH_2 = 7'h24;
    localparam seg_t GLYPH_3 = 7'h30;
    localparam seg_t GLYPH_4 = 7'h19;
    localparam seg_t GLYPH_5 = 7'h12;
    localparam seg_t GLYPH_6 = 7'h02;
    localparam seg_t GLYPH_7 = 7'h78;
    localparam seg_t GLYPH_8 = 7'h00;
    localparam seg_t GLYPH_9 = 7'h10;
    localparam seg_t GLYPH_A = 7'h08;
    localparam seg_t GLYPH_B = 7'h03;
    localparam seg_t GLYPH_C = 7'h46;
    localparam seg_t GLYPH_D = 7'h21;
    localparam seg_t GLYPH_E = 7'h06;
    localparam seg_t GLYPH_F = 7'h0E;

endpackage

// File: rtl/hex_scan_display_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
    import hex_scan_display_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_WIDTH-1:0] seg_n
);

    always_comb begin
        // NOTE: default assigned first so every path drives seg_n and no latch is inferred.
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = GLYPH_0;
            4'h1: seg_n = GLYPH_1;
            4'h2: seg_n = GLYPH_2;
            4'h3: seg_n = GLYPH_3;
            4'h4: seg_n = GLYPH_4;
            4'h5: seg_n = GLYPH_5;
            4'h6: seg_n = GLYPH_6;
            4'h7: seg_n = GLYPH_7;
            4'h8: seg_n = GLYPH_8;
            4'h9: seg_n = GLYPH_9;
            4'hA: seg_n = GLYPH_A;
            4'hB: seg_n = GLYPH_B;
            4'hC: seg_n = GLYPH_C;
            4'hD: seg_n = GLYPH_D;
            4'hE: seg_n = GLYPH_E;
            4'hF: seg_n = GLYPH_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed seven-segment scan driver; new words are adopted only at frame wraps.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000
)(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [31:0]          wr_data,
    output logic [DIGITS-1:0]    an_n,
    output logic [SEG_WIDTH-1:0] seg_n,
    output logic                 frame_tick,
    output logic [31:0]          shown
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]        pcnt;
    logic [IW-1:0]        idx;
    logic [31:0]          pend;
    logic                 pend_v;
    logic                 digit_tick;
    logic                 frame_wrap;
    logic [3:0]           nibble;
    logic [SEG_WIDTH-1:0] glyph_seg;
    logic [DIGITS-1:0]    digit_onehot;
    logic                 blank;

    assign digit_tick   = (pcnt == PCNT_MAX);
    assign frame_wrap   = digit_tick && (idx == IDX_MAX);
    assign nibble       = shown[{idx, 2'b00} +: 4];
    assign digit_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (digit_tick) begin
            pcnt <= '0;
            idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
        end
    end

    // A write landing on the wrap cycle bypasses pend so it shows without an extra frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend   <= '0;
            pend_v <= 1'b0;
            shown  <= '0;
        end else begin
            if (wr_en) begin
                pend <= wr_data;
            end
            if (frame_wrap) begin
                pend_v <= 1'b0;
                if (wr_en) begin
                    shown <= wr_data;
                end else if (pend_v) begin
                    shown <= pend;
                end
            end else if (wr_en) begin
                pend_v <= 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .seg_n  (glyph_seg)
    );

`ifdef HEX_SCAN_LZB_EN
    logic [31:0] upper_bits;

    // Blank when this nibble and every higher nibble of shown are zero.
    assign upper_bits = shown >> {idx, 2'b00};
    assign blank      = (idx != '0) && (upper_bits == '0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
        end else if (blank) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= ~digit_onehot;
            seg_n <= glyph_seg;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (PRESCALE=4, DIGITS=8): stimulus queues
// expected words, a monitor checks scan outputs every cycle and pops at frame_tick.
module tb_hex_scan_display;

    localparam int DIGITS   = 8;
    localparam int PRESCALE = 4;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_tick;
    logic [31:0] shown;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_exp = '0;
    int          n = 0;

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clock = ~clock;

    hex_scan_display #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick),
        .shown      (shown)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic write_word(input logic [31:0] data);
        wr_en   = 1'b1;
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (frame_tick !== 1'b1 && k < 2 * FRAME);
        check("frame_wait", {31'b0, frame_tick}, 32'd1);
    endtask

    // Monitor: n counts clock edges since reset release; outputs at edge n show idx ((n-1)/4)%8.
    initial begin
        int          d;
        logic [31:0] upper;
        logic [3:0]  nib;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                n       = 0;
                cur_exp = '0;
                check("rst_an_n", {24'b0, an_n}, 32'hFF);
                check("rst_seg_n", {25'b0, seg_n}, 32'h7F);
                check("rst_frame_tick", {31'b0, frame_tick}, 32'd0);
                check("rst_shown", shown, 32'd0);
            end else begin
                n++;
                d     = ((n - 1) / PRESCALE) % DIGITS;
                upper = cur_exp >> (4 * d);
                nib   = upper[3:0];
                e_an  = ~(8'b1 << d);
                e_seg = glyph_tab[nib];
`ifdef HEX_SCAN_LZB_EN
                if (d != 0 && upper == 32'd0) begin
                    e_an  = 8'hFF;
                    e_seg = 7'h7F;
                end
`endif
                check("an_n", {24'b0, an_n}, {24'b0, e_an});
                check("seg_n", {25'b0, seg_n}, {25'b0, e_seg});
                check("frame_tick", {31'b0, frame_tick}, {31'b0, (n % FRAME) == 0});
                if (frame_tick === 1'b1 && exp_q.size() > 0) begin
                    cur_exp = exp_q.pop_front();
                end
                check("shown", shown, cur_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Release between edges so the edge count starts cleanly.
        #22 resetn = 1'b1;

        // Idle frames: all digits show 0.
        wait_frame();
        wait_frame();

        // Mid-frame write shows only after the wrap.
        wait_cycles(12);
        exp_q.push_back(32'h1234_5678);
        write_word(32'h1234_5678);
        check("pend_v_after_write", {31'b0, dut.pend_v}, 32'd1);
        check("shown_before_wrap", shown, 32'd0);
        wait_frame();
        check("shown_after_wrap", shown, 32'h1234_5678);
        wait_frame();

        // Last write in a frame wins.
        wait_cycles(3);
        write_word(32'hAAAA_AAAA);
        wait_cycles(4);
        exp_q.push_back(32'h0000_00F0);
        write_word(32'h0000_00F0);
        wait_frame();
        check("last_write_wins", shown, 32'h0000_00F0);
        wait_frame();

        // Write exactly on the wrap cycle bypasses the pending register.
        wait_cycles(FRAME - 1);
        exp_q.push_back(32'hDEAD_BEEF);
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clock);
        wr_en   = 1'b0;
        check("wrap_write_tick", {31'b0, frame_tick}, 32'd1);
        check("wrap_write_shown", shown, 32'hDEAD_BEEF);
        check("wrap_write_pend_v", {31'b0, dut.pend_v}, 32'd0);
        wait_frame();

        // Asynchronous reset with a pending write discards it.
        wait_cycles(10);
        write_word(32'h5555_1111);
        check("pend_v_before_reset", {31'b0, dut.pend_v}, 32'd1);
        wait_cycles(3);
        #2 resetn = 1'b0;
        #1;
        check("async_an_n", {24'b0, an_n}, 32'hFF);
        check("async_seg_n", {25'b0, seg_n}, 32'h7F);
        check("async_frame_tick", {31'b0, frame_tick}, 32'd0);
        check("async_shown", shown, 32'd0);
        check("async_pend_v", {31'b0, dut.pend_v}, 32'd0);
        wait_cycles(3);
        #2 resetn = 1'b1;
        wait_frame();
        check("post_reset_shown", shown, 32'd0);
        wait_frame();

        // Remaining glyphs, then a word exercising leading-zero blanking.
        wait_cycles(5);
        exp_q.push_back(32'h9ABC_DEF0);
        write_word(32'h9ABC_DEF0);
        wait_frame();
        wait_cycles(5);
        exp_q.push_back(32'h0000_0102);
        write_word(32'h0000_0102);
        wait_frame();
        wait_frame();

        wait_cycles(2);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
